// File: rtl/aes_round_sequencer_pkg.sv
// Shared definitions for the AES round sequencer: FSM state encoding,
// key-size codes, round counts and the key-size to round-count mapping.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        KS_128  = 2'b00,
        KS_192  = 2'b01,
        KS_256  = 2'b10,
        KS_RSVD = 2'b11
    } key_size_e;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Reserved code 11 falls back to AES-128.
    function automatic logic [3:0] key_size_to_nr(input logic [1:0] ks);
        logic [3:0] nr;
        case (ks)
            KS_192:  nr = NR_192;
            KS_256:  nr = NR_256;
            default: nr = NR_128;
        endcase
        return nr;
    endfunction

endpackage

// File: rtl/aes_round_sequencer_round_counter.sv
// Round counter: clear / load / increment with async active-high reset.
// The next-state value is exported so the sequencer can register flags
// that depend on the upcoming round number.
module round_counter #(
    parameter int CW = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [CW-1:0] count_o,
    output logic [CW-1:0] count_next_o
);

    localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins over load, load wins over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = {CW{1'b0}};
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (inc_i) begin
            count_d = count_q + ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;

endmodule

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: steps one block through initial AddRoundKey,
// rounds 1..Nr-1 and the final round, pulsing a go strobe per step and
// waiting for the datapath acknowledge. A per-step watchdog aborts a hung
// datapath. All outputs come straight from flops.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int CW         = 4,
    parameter int WAIT_LIMIT = 255,
    parameter int WW         = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    key_size,
    input  logic          abort,
    output logic          init_go,
    output logic          round_go,
    output logic          last_round,
    output logic [CW-1:0] round_idx,
    input  logic          dp_ack,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          err
);

    localparam logic [WW-1:0] WD_LAST = WW'(WAIT_LIMIT - 1);
    localparam logic [WW-1:0] WD_ONE  = {{(WW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] IDX_ONE = {{(CW-1){1'b0}}, 1'b1};

    seq_state_e    state_q, state_d;
    logic [CW-1:0] nr_q, nr_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          init_go_q, init_go_d;
    logic          round_go_q, round_go_d;
    logic          last_round_q, last_round_d;
    logic          out_valid_q, out_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          cnt_clr_s, cnt_load_s, cnt_inc_s;
    logic [CW-1:0] idx_s, idx_next_s;

    round_counter #(.CW(CW)) u_round_counter (
        .clock        (clock),
        .reset        (reset),
        .clr_i        (cnt_clr_s),
        .load_i       (cnt_load_s),
        .load_val_i   (IDX_ONE),
        .inc_i        (cnt_inc_s),
        .count_o      (idx_s),
        .count_next_o (idx_next_s)
    );

    // Next-state, counter control, watchdog and next registered outputs.
    always_comb begin
        state_d    = state_q;
        nr_d       = nr_q;
        wd_d       = wd_q;
        init_go_d  = 1'b0;
        round_go_d = 1'b0;
        err_d      = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    nr_d      = CW'(key_size_to_nr(key_size));
                    cnt_clr_s = 1'b1;
                    wd_d      = {WW{1'b0}};
                    init_go_d = 1'b1;
                    state_d   = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT, ROUND: begin
                if (abort) begin
                    cnt_clr_s = 1'b1;
                    wd_d      = {WW{1'b0}};
                    state_d   = IDLE;
                end else if (dp_ack) begin
                    wd_d = {WW{1'b0}};
                    if (state_q == INIT) begin
                        cnt_load_s = 1'b1;
                        round_go_d = 1'b1;
                        state_d    = ROUND;
                    end else if (idx_s == nr_q) begin
                        state_d = DONE;
                    end else begin
                        cnt_inc_s  = 1'b1;
                        round_go_d = 1'b1;
                        state_d    = ROUND;
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d     = 1'b1;
                    cnt_clr_s = 1'b1;
                    wd_d      = {WW{1'b0}};
                    state_d   = IDLE;
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    cnt_clr_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                cnt_clr_s = 1'b1;
                wd_d      = {WW{1'b0}};
                state_d   = IDLE;
            end
        endcase
        in_ready_d   = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
        out_valid_d  = (state_d == DONE);
        last_round_d = (state_d == ROUND) && (idx_next_s == nr_d);
    end

    // State, latched round count, watchdog and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            nr_q         <= {CW{1'b0}};
            wd_q         <= {WW{1'b0}};
            init_go_q    <= 1'b0;
            round_go_q   <= 1'b0;
            last_round_q <= 1'b0;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nr_q         <= nr_d;
            wd_q         <= wd_d;
            init_go_q    <= init_go_d;
            round_go_q   <= round_go_d;
            last_round_q <= last_round_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign init_go    = init_go_q;
    assign round_go   = round_go_q;
    assign last_round = last_round_q;
    assign round_idx  = idx_s;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: directed timing checks plus
// an event scoreboard (init / round / done / err) fed as each block starts.
module tb_aes_round_sequencer;

    localparam int CW = 4;
    localparam int WW = 8;
    localparam int WL = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    key_size = 2'b00;
    logic          abort = 1'b0;
    logic          init_go, round_go, last_round;
    logic [CW-1:0] round_idx;
    logic          dp_ack = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy, err;

    aes_round_sequencer #(.CW(CW), .WAIT_LIMIT(WL), .WW(WW)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .key_size(key_size), .abort(abort), .init_go(init_go), .round_go(round_go),
        .last_round(last_round), .round_idx(round_idx), .dp_ack(dp_ack),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {int kind; int idx; int last;} ev_t;  // kind 0 init,1 round,2 done,3 err
    ev_t sb_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int go_cnt   = 0;
    int go3_cyc  = -1;
    int err_cyc  = -1;
    bit ov_seen  = 1'b0;
    bit ov_prev  = 1'b0;

    bit ack_tied     = 1'b1;
    int ack_delay    = 0;
    int withhold_idx = -1;
    bit pend         = 1'b0;
    int acnt         = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic mon_event(input int kind, input int idx, input int last);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected_event", kind, -1);
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_kind", kind, e.kind);
            check_eq("sb_idx", idx, e.idx);
            check_eq("sb_last", last, e.last);
        end
    endtask

    // Expected events: init, rounds 1..min(nr,stop), then end_kind (-1 none).
    task automatic push_run(input int nr, input int stop, input int end_kind);
        ev_t e;
        e.kind = 0; e.idx = 0; e.last = 0; sb_q.push_back(e);
        for (int r = 1; r <= nr && r <= stop; r++) begin
            e.kind = 1; e.idx = r; e.last = (r == nr) ? 1 : 0; sb_q.push_back(e);
        end
        if (end_kind == 2) begin
            e.kind = 2; e.idx = nr; e.last = 0; sb_q.push_back(e);
        end else if (end_kind == 3) begin
            e.kind = 3; e.idx = 0; e.last = 0; sb_q.push_back(e);
        end
    endtask

    always @(posedge clock) cyc++;

    // Output monitor: turns DUT strobes into scoreboard events.
    always @(negedge clock) begin
        if (!reset) begin
            if (init_go || round_go) go_cnt++;
            if (round_go && round_idx == 4'd3) go3_cyc = cyc;
            if (init_go)  mon_event(0, int'(round_idx), int'(last_round));
            if (round_go) mon_event(1, int'(round_idx), int'(last_round));
            if (out_valid && !ov_prev) mon_event(2, int'(round_idx), int'(last_round));
            if (out_valid) ov_seen = 1'b1;
            if (err) begin
                err_cyc = cyc;
                mon_event(3, int'(round_idx), int'(last_round));
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    // Datapath model: ack tied high, or ack ack_delay cycles after each go.
    always @(negedge clock) begin
        if (reset) begin
            pend   = 1'b0;
            dp_ack = 1'b0;
        end else if (ack_tied) begin
            dp_ack = 1'b1;
        end else begin
            dp_ack = 1'b0;
            if (init_go || round_go) begin
                pend = 1'b0;
                if (!(round_go && int'(round_idx) == withhold_idx)) begin
                    if (ack_delay == 0) dp_ack = 1'b1;
                    else begin pend = 1'b1; acnt = ack_delay; end
                end
            end else if (pend) begin
                acnt--;
                if (acnt == 0) begin dp_ack = 1'b1; pend = 1'b0; end
            end
        end
    end

    task automatic start_block(input logic [1:0] ks);
        @(posedge clock); #1;
        in_valid = 1'b1; key_size = ks;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_ov(input string tag, input int budget);
        int n = 0;
        @(negedge clock);
        while (!out_valid && n < budget) begin @(negedge clock); n++; end
        check_eq(tag, out_valid, 1);
    endtask

    task automatic finish_done();
        @(posedge clock); #1; out_ready = 1'b1;
        @(posedge clock); #1; out_ready = 1'b0;
    endtask

    initial begin
        int n;
        int go_snap;
        // Reset state
        #12;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_round_idx", round_idx, 0);
        check_eq("rst_out_valid", out_valid, 0);
        @(negedge clock); reset = 1'b0;

        // AES-128, ack tied high: exact cycle timing
        push_run(10, 99, 2);
        @(posedge clock); #1; in_valid = 1'b1; key_size = 2'b00;
        @(negedge clock);
        check_eq("t1_in_ready_c0", in_ready, 1);
        for (int k = 1; k <= 13; k++) begin
            @(posedge clock); #1;
            in_valid  = 1'b0;
            out_ready = (k == 12);
            @(negedge clock);
            check_eq("t1_init_go", init_go, (k == 1));
            check_eq("t1_round_go", round_go, (k >= 2 && k <= 11));
            check_eq("t1_last_round", last_round, (k == 11));
            check_eq("t1_out_valid", out_valid, (k == 12));
            check_eq("t1_in_ready", in_ready, (k == 13));
            if (k == 1) check_eq("t1_idx", round_idx, 0);
            else if (k <= 11) check_eq("t1_idx", round_idx, k - 1);
            else if (k == 12) check_eq("t1_idx", round_idx, 10);
            else check_eq("t1_idx", round_idx, 0);
        end
        out_ready = 1'b0;
        check_eq("t1_sb_empty", sb_q.size(), 0);

        // AES-256, ack 3 cycles after each go, out_valid held 5 cycles
        ack_tied = 1'b0; ack_delay = 3; go_cnt = 0;
        push_run(14, 99, 2);
        start_block(2'b10);
        wait_ov("t2_ov_timeout", 200);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock); #1;
            if (i == 4) out_ready = 1'b1;
            @(negedge clock);
            check_eq("t2_ov_held", out_valid, 1);
        end
        @(posedge clock); #1; out_ready = 1'b0;
        @(negedge clock);
        check_eq("t2_ov_drop", out_valid, 0);
        check_eq("t2_in_ready", in_ready, 1);
        check_eq("t2_go_cnt", go_cnt, 15);
        check_eq("t2_sb_empty", sb_q.size(), 0);

        // key_size 11 -> 10 rounds
        ack_tied = 1'b1; go_cnt = 0;
        push_run(10, 99, 2);
        start_block(2'b11);
        wait_ov("t3a_ov_timeout", 100);
        check_eq("t3a_go_cnt", go_cnt, 11);
        finish_done();

        // key_size 01 -> 12 rounds, key_size toggled mid-run
        go_cnt = 0;
        push_run(12, 99, 2);
        start_block(2'b01);
        @(posedge clock); #1; key_size = 2'b10;
        @(posedge clock); #1; key_size = 2'b00;
        wait_ov("t3b_ov_timeout", 100);
        check_eq("t3b_go_cnt", go_cnt, 13);
        finish_done();
        check_eq("t3_sb_empty", sb_q.size(), 0);

        // Watchdog: ack withheld in round 3
        ack_tied = 1'b0; ack_delay = 0; withhold_idx = 3;
        go3_cyc = -1; err_cyc = -1; ov_seen = 1'b0;
        push_run(10, 3, 3);
        start_block(2'b00);
        n = 0;
        while (err_cyc < 0 && n < 50) begin @(negedge clock); n++; end
        check_eq("t4_err_seen", (err_cyc >= 0), 1);
        check_eq("t4_err_delay", err_cyc - go3_cyc, WL);
        check_eq("t4_busy", busy, 0);
        check_eq("t4_in_ready", in_ready, 1);
        @(negedge clock);
        check_eq("t4_err_pulse", err, 0);
        check_eq("t4_no_ov", ov_seen, 0);
        check_eq("t4_sb_empty", sb_q.size(), 0);
        withhold_idx = -1;

        // Abort in round 5 concurrent with ack, then stray acks in IDLE
        ack_tied = 1'b1; err_cyc = -1;
        push_run(10, 5, -1);
        start_block(2'b00);
        n = 0;
        while (!(round_go && round_idx == 4'd5) && n < 50) begin @(negedge clock); n++; end
        check_eq("t5_reached_r5", (round_go && round_idx == 4'd5), 1);
        abort = 1'b1;
        @(posedge clock); #1; abort = 1'b0;
        @(negedge clock);
        check_eq("t5_busy", busy, 0);
        check_eq("t5_in_ready", in_ready, 1);
        check_eq("t5_idx", round_idx, 0);
        check_eq("t5_err", err, 0);
        go_snap = go_cnt;
        repeat (4) @(negedge clock);
        check_eq("t5_no_go", go_cnt, go_snap);
        check_eq("t5_idle_busy", busy, 0);
        check_eq("t5_no_err", (err_cyc < 0), 1);
        check_eq("t5_sb_empty", sb_q.size(), 0);

        // Async reset mid-round 7
        ack_tied = 1'b0; ack_delay = 2;
        push_run(10, 7, -1);
        start_block(2'b00);
        n = 0;
        while (!(round_go && round_idx == 4'd7) && n < 80) begin @(negedge clock); n++; end
        check_eq("t6_reached_r7", (round_go && round_idx == 4'd7), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_idx", round_idx, 0);
        check_eq("t6_rst_in_ready", in_ready, 1);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_round_go", round_go, 0);
        check_eq("t6_rst_last", last_round, 0);
        @(negedge clock); reset = 1'b0;
        go_cnt = 0;
        @(negedge clock);
        check_eq("t6_rel_go", go_cnt, 0);
        check_eq("t6_rel_busy", busy, 0);
        check_eq("t6_sb_empty", sb_q.size(), 0);
        ack_tied = 1'b1;
        push_run(10, 99, 2);
        start_block(2'b00);
        wait_ov("t6_ov_timeout", 100);
        check_eq("t6_go_cnt", go_cnt, 11);
        finish_done();
        check_eq("t6_sb_final", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
